// File: rtl/spi_prefetch_fetch.sv
// SPI-SRAM instruction fetch unit: one long READ burst streams words ahead of the PC
// into a small tagged FIFO; a non-sequential request flushes it and restarts the burst.
module spi_prefetch_fetch #(
  parameter int          INSTR_W        = 16,
  parameter int          ADDR_W         = 16,
  parameter int          SPI_ADDR_BYTES = 2,
  parameter int          DEPTH          = 4,
  parameter int          CLK_DIV        = 1,
  parameter logic [7:0]  READ_CMD       = 8'h03
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ADDR_W-1:0]  fetch_addr,
  input  logic               fetch_req,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               spi_cs_n,
  output logic               spi_sck,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  localparam int AB_W    = 8 * SPI_ADDR_BYTES;
  localparam int TX_W    = 8 + AB_W;
  localparam int BYTES   = INSTR_W / 8;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W   = $clog2(2 * CLK_DIV + 1);
  localparam int BIT_MAX = (AB_W > INSTR_W) ? AB_W : INSTR_W;
  localparam int BIT_W   = $clog2(BIT_MAX);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;
  state_t state, state_next;

  logic [DIV_W-1:0]   div_cnt;
  logic               sck;
  logic [BIT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TX_W-1:0]    tx_sr;
  logic [INSTR_W-1:0] rx_sr;
  logic [ADDR_W-1:0]  stream_addr;
  logic [ADDR_W-1:0]  tag_mem  [DEPTH];
  logic [INSTR_W-1:0] word_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;

  function automatic logic [AB_W-1:0] to_byte(input logic [ADDR_W-1:0] a);
    logic [63:0] p;
    p = 64'(a) * 64'(BYTES);
    return p[AB_W-1:0];
  endfunction

  logic empty, full, hit, pending, miss, shifting, stall;
  logic phase_done, sck_rise, sck_fall, push;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] word_in;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign hit      = en && fetch_req && !empty && (tag_mem[rd_ptr] == fetch_addr);
  // The address already being fetched is waited for in any active state, so a CPU
  // holding its request through CMD/ADDR/GAP does not keep restarting the burst.
  assign pending  = en && fetch_req && empty && (state != IDLE) && (stream_addr == fetch_addr);
  assign miss     = en && fetch_req && !hit && !pending;
  assign shifting = (state == CMD) || (state == ADDR) || (state == DATA);
  assign stall    = (state == DATA) && !sck && full && !hit;
  assign phase_done = shifting && !stall && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sck_rise = phase_done && !sck;
  assign sck_fall = phase_done && sck;
  assign push     = (state == DATA) && sck_rise && (bit_cnt == BIT_W'(INSTR_W - 1));
  assign word_in  = {rx_sr[INSTR_W-2:0], spi_miso};
  assign load_addr = miss ? fetch_addr : stream_addr;

  always_ff @(posedge clk) begin
    if (rst || !en) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (miss) state_next = CMD;
      CMD:  if (miss) state_next = GAP;
            else if (sck_fall && bit_cnt == BIT_W'(7)) state_next = ADDR;
      ADDR: if (miss) state_next = GAP;
            else if (sck_fall && bit_cnt == BIT_W'(AB_W - 1)) state_next = DATA;
      DATA: if (miss) state_next = GAP;
      GAP:  if (gap_cnt == GAP_W'(2 * CLK_DIV - 1)) state_next = CMD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    spi_cs_n    = (state == IDLE) || (state == GAP);
    busy        = !spi_cs_n;
    spi_sck     = sck;
    spi_mosi    = ((state == CMD) || (state == ADDR)) ? tx_sr[TX_W-1] : 1'b0;
    instr_valid = hit;
    instr       = hit ? word_mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      sck         <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      stream_addr <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (!shifting || state_next == GAP) begin
        sck     <= 1'b0;
        div_cnt <= '0;
      end else if (phase_done) begin
        sck     <= ~sck;
        div_cnt <= '0;
      end else if (!stall) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (state_next != state)                      bit_cnt <= '0;
      else if ((state == CMD || state == ADDR) && sck_fall) bit_cnt <= bit_cnt + BIT_W'(1);
      else if (state == DATA && sck_rise)            bit_cnt <= push ? '0 : bit_cnt + BIT_W'(1);

      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (state_next == CMD && state != CMD)
        tx_sr <= {READ_CMD, to_byte(load_addr)};
      else if ((state == CMD || state == ADDR) && sck_fall)
        tx_sr <= tx_sr << 1;

      if (state == DATA && sck_rise) rx_sr <= word_in;

      if (miss)      stream_addr <= fetch_addr;
      else if (push) stream_addr <= stream_addr + ADDR_W'(1);

      // A flush on the same edge as a push discards the pushed word.
      if (miss) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (hit)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !hit)      count <= count + (PTR_W+1)'(1);
        else if (!push && hit) count <= count - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !miss) begin
      tag_mem[wr_ptr]  <= stream_addr;
      word_mem[wr_ptr] <= word_in;
    end
  end

endmodule

// File: tb/tb_spi_prefetch_fetch.sv
// Directed bench for spi_prefetch_fetch with a behavioural mode-0 SPI SRAM on the bus.
module tb_spi_prefetch_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] fetch_addr = '0;
  logic        fetch_req = 1'b0;
  logic [15:0] instr;
  logic        instr_valid, busy, spi_cs_n, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  spi_prefetch_fetch dut (
    .clk(clk), .rst(rst), .en(en), .fetch_addr(fetch_addr), .fetch_req(fetch_req),
    .instr(instr), .instr_valid(instr_valid), .busy(busy), .spi_cs_n(spi_cs_n),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM model: 16-bit byte address, word contents fixed by mem_word.
  int          nbits = 0;
  int          n_cmds = 0;
  int          cs_rises = 0;
  logic [23:0] cmd_sr = '0;
  logic [23:0] last_cmd = '0;
  int          hi_run = 0;
  int          last_hi_run = 0;

  function automatic logic [15:0] mem_word(input logic [14:0] w);
    case (w)
      15'd0:   return 16'h1234;
      15'd1:   return 16'hA001;
      15'd2:   return 16'hA002;
      15'd3:   return 16'hA003;
      15'd4:   return 16'hA004;
      default: return 16'h5000 + {1'b0, w};
    endcase
  endfunction

  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      if (nbits < 24) begin
        cmd_sr = {cmd_sr[22:0], spi_mosi};
        if (nbits == 23) begin
          last_cmd = cmd_sr;
          n_cmds++;
        end
      end
      nbits++;
    end
  end

  always @(negedge spi_sck) begin
    int          k;
    logic [14:0] w;
    logic [15:0] wd;
    if (!spi_cs_n && nbits >= 24) begin
      k  = nbits - 24;
      w  = cmd_sr[15:1] + 15'(k / 16);
      wd = mem_word(w);
      spi_miso <= wd[15 - (k % 16)];
    end
  end

  always @(posedge spi_cs_n) begin
    nbits = 0;
    cs_rises++;
  end

  always @(negedge clk) begin
    if (spi_cs_n) hi_run++;
    else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic fetch(input string tag, input logic [15:0] a, input logic [15:0] exp,
                       input int budget, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    fetch_addr = a;
    fetch_req = 1'b1;
    while (!got && lat < budget) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1'b1;
        check({tag, "_instr"}, 32'(instr), 32'(exp));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    fetch_req = 1'b0;
    check({tag, "_valid"}, 32'(got), 32'd1);
    $display("fetch %s addr=%h instr=%h lat=%0d", tag, a, instr, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r0, c0, waited;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (10) begin
      @(negedge clk);
      check("idle_cs_n", 32'(spi_cs_n), 32'd1);
      check("idle_sck", 32'(spi_sck), 32'd0);
      check("idle_mosi", 32'(spi_mosi), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(instr_valid), 32'd0);
      check("idle_instr", 32'(instr), 32'd0);
    end
    @(posedge clk);
    #1;

    // Cold start at word 0
    fetch("cold", 16'h0000, 16'h1234, 100, lat);
    check("cold_lat_le84", 32'(lat <= 84), 32'd1);
    check("cold_cmd", 32'(last_cmd), 32'h030000);

    // Sequential run: all served from the same burst
    r0 = cs_rises;
    c0 = n_cmds;
    for (int i = 1; i <= 4; i++) begin
      fetch("seq", 16'(i), 16'hA000 + 16'(i), 40, lat);
      check("seq_lat", 32'(lat <= 33), 32'd1);
    end
    check("seq_cs_rises", 32'(cs_rises), 32'(r0));
    check("seq_cmds", 32'(n_cmds), 32'(c0));

    // Branch while streaming
    fetch("branch", 16'h0040, 16'h5040, 100, lat);
    check("branch_cmd", 32'(last_cmd), 32'h030080);
    check("branch_gap_ge2", 32'(last_hi_run >= 2), 32'd1);
    check("branch_lat", 32'(lat <= 88), 32'd1);

    // Back-pressure: 0x40 consumed, 0x41..0x44 buffered, then SCK frozen
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("bp_bits", 32'(nbits), 32'd104);
    check("bp_sck", 32'(spi_sck), 32'd0);
    check("bp_cs_n", 32'(spi_cs_n), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      fetch("bp_hit", 16'h0040 + 16'(i), 16'h5040 + 16'(i), 4, lat);
      check("bp_hit_lat", 32'(lat), 32'd1);
    end
    fetch("bp_next", 16'h0045, 16'h5045, 40, lat);

    // Reset pulse in the middle of the address phase
    r0 = cs_rises;
    fetch_addr = 16'h0010;
    fetch_req = 1'b1;
    waited = 0;
    while (!(cs_rises != r0 && nbits >= 12 && !spi_cs_n) && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("abort_reached_addr", 32'(waited < 200), 32'd1);
    rst = 1'b1;
    fetch_req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sck", 32'(spi_sck), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fetch("fresh", 16'h0002, 16'hA002, 100, lat);
    check("fresh_cmd", 32'(last_cmd), 32'h030004);
    check("fresh_lat", 32'(lat <= 84), 32'd1);

    // Address wrap through 0xFFFF
    fetch("wrap_fffe", 16'hFFFE, 16'hCFFE, 100, lat);
    check("wrap_cmd", 32'(last_cmd), 32'h03FFFC);
    fetch("wrap_ffff", 16'hFFFF, 16'hCFFF, 40, lat);
    fetch("wrap_0000", 16'h0000, 16'h1234, 40, lat);

    // en=0 aborts like a reset
    en = 1'b0;
    @(posedge clk);
    #1;
    check("en_cs_n", 32'(spi_cs_n), 32'd1);
    check("en_busy", 32'(busy), 32'd0);
    check("en_sck", 32'(spi_sck), 32'd0);
    en = 1'b1;
    fetch("after_en", 16'h0003, 16'hA003, 100, lat);
    check("after_en_cmd", 32'(last_cmd), 32'h030006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
